// File: rtl/pipeline_credit_sink_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_credit_sink_pkg
//
// Shared constants and helpers for the credit-gated pipeline sink.
//   DEFAULT_DATA_WIDTH : default payload width
//   DEFAULT_LATENCY    : default pipeline latency (cycles, 1..8)
//   DEFAULT_DEPTH      : default result buffer depth (power of two, >= 2)
//   credit_width()     : bits needed to hold a count in 0..depth inclusive
//   credit_op_e        : what the credit counter does in a given cycle
// ---------------------------------------------------------------------------
package pipeline_credit_sink_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LATENCY    = 1;
    localparam int DEFAULT_DEPTH      = 4;

    // A counter that must represent both 0 and depth needs one bit more
    // than the pointer width.
    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        CREDIT_HOLD   = 2'd0,  // no change (idle, or issue and pop together)
        CREDIT_TAKE   = 2'd1,  // issue only: reserve one slot
        CREDIT_RETURN = 2'd2   // pop only: release one slot
    } credit_op_e;

endpackage

// File: rtl/pipeline_credit_fifo.sv
// ---------------------------------------------------------------------------
// pipeline_credit_fifo
//
// Result buffer that sits behind a no-stall pipeline. Show-ahead read: the
// entry at the read pointer is always visible on rd_data. There is no
// empty-buffer bypass, so a result written in cycle t shows up in t+1.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   push       : pipeline result valid this cycle
//   push_data  : pipeline result
//   pop        : downstream takes the head entry (ignored when empty)
//   rd_data    : head entry
//   rd_valid   : buffer holds at least one entry
//   overflow   : sticky, a push arrived while full with no pop to make room
// ---------------------------------------------------------------------------
module pipeline_credit_fifo
    import pipeline_credit_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = credit_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Storage carries no reset; validity is tracked by count_reg alone.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;

    logic full;
    logic do_pop;
    logic do_push;

    assign full    = (count_reg == DEPTH_C);
    assign do_pop  = pop && (count_reg != '0);
    // A pop in the same cycle frees the head slot, so a push into a full
    // buffer is still taken when it coincides with a pop.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural
            // roll-over of an AW-bit counter.
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (push && !do_push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign rd_data  = mem[rd_ptr_reg];
    assign rd_valid = (count_reg != '0);
    assign overflow = overflow_reg;

endmodule

// File: rtl/pipeline_credit_sink.sv
// ---------------------------------------------------------------------------
// pipeline_credit_sink
//
// Front end for a fixed-latency, valid-only pipeline that cannot stall.
// A request is only issued when a result slot has been reserved for it, so
// every result the pipeline produces has room in the buffer. Credits count
// the slots that are neither occupied nor reserved by in-flight requests.
//
// Ports
//   clk, rst           : clock, synchronous active-high reset (also resets
//                        the attached pipeline outside this block)
//   in_data/in_valid   : upstream request
//   in_ready           : a credit is available (registers only)
//   pipe_x             : request payload into the pipeline
//   pipe_input_valid   : request issued this cycle
//   pipe_out           : pipeline result
//   pipe_output_valid  : pipeline result valid
//   out_data/out_valid : oldest buffered result (show-ahead)
//   out_ready          : downstream accepts out_data
//   credits            : free, unreserved result slots
//   overflow           : sticky, a result arrived with the buffer full
// ---------------------------------------------------------------------------
module pipeline_credit_sink
    import pipeline_credit_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            pipe_x,
    output logic                             pipe_input_valid,
    input  logic [DATA_WIDTH-1:0]            pipe_out,
    input  logic                             pipe_output_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [credit_width(DEPTH)-1:0]   credits,
    output logic                             overflow
);

    localparam int CW = credit_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] credits_reg;
    logic [CW-1:0] credits_next;
    credit_op_e    credit_op;

    logic issue;
    logic pop;

    // in_ready depends only on the credit register, never on in_valid, so
    // upstream can use it without forming a combinational loop.
    assign in_ready         = (credits_reg != '0);
    assign issue            = in_valid && in_ready;
    assign pipe_input_valid = issue;
    assign pipe_x           = in_data;
    assign pop              = out_valid && out_ready;

    always_comb begin
        credit_op = CREDIT_HOLD;
        if (issue && !pop) begin
            credit_op = CREDIT_TAKE;
        end else if (pop && !issue) begin
            credit_op = CREDIT_RETURN;
        end
    end

    // Saturate at DEPTH: a stray pipeline result accepted together with a
    // pop would otherwise hand back a credit that was never taken.
    always_comb begin
        credits_next = credits_reg;
        case (credit_op)
            CREDIT_TAKE:   credits_next = credits_reg - 1'b1;
            CREDIT_RETURN: begin
                if (credits_reg != DEPTH_C) begin
                    credits_next = credits_reg + 1'b1;
                end
            end
            default:       credits_next = credits_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_reg <= DEPTH_C;
        end else begin
            credits_reg <= credits_next;
        end
    end

    assign credits = credits_reg;

    pipeline_credit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_output_valid),
        .push_data (pipe_out),
        .pop       (pop),
        .rd_data   (out_data),
        .rd_valid  (out_valid),
        .overflow  (overflow)
    );

endmodule
